// File: rtl/encoder_pkg.sv
// Shared definitions for the quadrature encoder generator: FSM state codes,
// the forward/reverse A/B phase sequences and default widths.
package encoder_pkg;

  localparam int DEF_POS_W    = 32;
  localparam int DEF_PERIOD_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Entry i of a sequence sits at bits [2*i+1:2*i], AB packed as {a, b}.
  localparam logic [7:0] FWD_SEQ = {2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [7:0] REV_SEQ = {2'b01, 2'b11, 2'b10, 2'b00};

  // Phase that follows ab in the chosen direction; one bit changes per call.
  function automatic logic [1:0] next_phase(input logic [1:0] ab, input logic fwd);
    logic [7:0] seq;
    logic [1:0] nxt;
    seq = fwd ? FWD_SEQ : REV_SEQ;
    nxt = seq[1:0];
    for (int i = 0; i < 4; i++) begin
      if (seq[2*i +: 2] == ab) nxt = seq[2*((i+1)%4) +: 2];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/encoder_edge_timer.sv
// Loadable down-counter: after a load of period P (0 treated as 1) it emits a
// one-cycle tick on every P-th cycle in which count_en is high.
module encoder_edge_timer
  import encoder_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                clear,
  input  logic                count_en,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period == '0) ? ONE : period;
  assign tick       = count_en && (count == ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      period_q <= '0;
    end else if (clear) begin
      count    <= '0;
    end else if (load) begin
      count    <= period_eff;
      period_q <= period_eff;
    end else if (count_en) begin
      // Reload on the tick so successive steps stay exactly P cycles apart.
      if (count == ONE)       count <= period_q;
      else if (count != '0)   count <= count - ONE;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder generator: accepts a signed step count and a step period,
// then walks enc_a/enc_b through the Gray phase sequence while tracking position.
module quad_encoder_gen
  import encoder_pkg::*;
#(
  parameter int POS_W    = DEF_POS_W,
  parameter int PERIOD_W = DEF_PERIOD_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [POS_W-1:0]    cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                enc_a,
  output logic                enc_b,
  output logic [POS_W-1:0]    position,
  output logic                direction,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  // Command handshake: a command transfers on a rising edge where
  // cmd_valid && cmd_ready; cmd_ready is high only in IDLE.

  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [1:0]       state;
  logic [1:0]       phase;
  logic [POS_W-1:0] remaining;
  logic [POS_W-1:0] step_mag;
  logic             accept;
  logic             steps_zero;
  logic             tick;
  logic             count_en;
  logic             last_step;
  logic             timer_clear;

  assign accept     = cmd_valid && (state == ST_IDLE);
  assign steps_zero = (cmd_steps == '0);
  // Two's-complement magnitude; the most negative value maps to 2^(POS_W-1).
  assign step_mag   = cmd_steps[POS_W-1] ? ((~cmd_steps) + POS_ONE) : cmd_steps;

  assign count_en    = enable && (state == ST_RUN);
  assign last_step   = tick && (remaining == POS_ONE);
  assign timer_clear = (state == ST_RUN) && (abort || last_step);

  encoder_edge_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (accept && !steps_zero),
    .clear    (timer_clear),
    .count_en (count_en),
    .period   (cmd_period),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase     <= 2'b00;
      position  <= '0;
      direction <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (steps_zero) begin
              state <= ST_DONE;
            end else begin
              remaining <= step_mag;
              direction <= !cmd_steps[POS_W-1];
              state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Abort wins over a step that falls due on the same edge.
          if (abort) begin
            remaining <= '0;
            state     <= ST_DONE;
          end else if (tick) begin
            phase     <= next_phase(phase, direction);
            position  <= direction ? (position + POS_ONE) : (position - POS_ONE);
            remaining <= remaining - POS_ONE;
            if (last_step) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign enc_a     = phase[1];
  assign enc_b     = phase[0];
  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule
